cmd_ctrl: RTL

Command sequencer between the UART receiver and the logic-analyzer core. It assembles the received byte stream into SUMP/OLS commands. Short commands are one opcode byte; long commands are an opcode plus four argument bytes. Each decoded command either writes a configuration register that drives the sampler, trigger and readout datapath, or issues a one-cycle action strobe to the capture/transmit sequencing.

---
 rtl/cmd_ctrl_if.sv | 36 +++
 rtl/cmd_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cmd_ctrl_if.sv
// Byte-stream input and decoded configuration/strobe outputs of the command sequencer.
// The receive side has no backpressure, so rx_stb_i is accepted on every cycle it is high.
interface cmd_ctrl_if;
  logic [7:0]  rx_data_i;
  logic        rx_stb_i;
  logic [23:0] cfg_div_o;
  logic [15:0] cfg_read_cnt_o;
  logic [15:0] cfg_delay_cnt_o;
  logic [15:0] cfg_flags_o;
  logic [31:0] trg_msk_o;
  logic [31:0] trg_val_o;
  logic [31:0] trg_cfg_o;
  logic        cfg_upd_o;
  logic        tx_en_o;
  logic        soft_reset_o;
  logic        run_o;
  logic        id_req_o;
  logic        meta_req_o;
  logic        finish_o;
  logic        query_in_o;
  logic        arm_o;

  modport master (
    output rx_data_i, rx_stb_i,
    input  cfg_div_o, cfg_read_cnt_o, cfg_delay_cnt_o, cfg_flags_o,
    input  trg_msk_o, trg_val_o, trg_cfg_o, cfg_upd_o, tx_en_o,
    input  soft_reset_o, run_o, id_req_o, meta_req_o, finish_o, query_in_o, arm_o
  );

  modport slave (
    input  rx_data_i, rx_stb_i,
    output cfg_div_o, cfg_read_cnt_o, cfg_delay_cnt_o, cfg_flags_o,
    output trg_msk_o, trg_val_o, trg_cfg_o, cfg_upd_o, tx_en_o,
    output soft_reset_o, run_o, id_req_o, meta_req_o, finish_o, query_in_o, arm_o
  );
endinterface

// File: rtl/cmd_ctrl.sv
// SUMP command sequencer: outputs update one cycle after the accepting strobe (opcode or 4th argument).
// No backpressure: a byte is consumed every strobed cycle; stalled long commands are dropped by a timeout.
module cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic     clk_i,
  input logic     rst_in,
  cmd_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, ARG} state_t;

  state_t        state, state_nxt;
  logic [1:0]    idx;
  logic [7:0]    opcode;
  logic [23:0]   arg_lo;
  logic [CW-1:0] tmo_cnt;
  logic          timeout;
  logic          short_cmd;
  logic          exec_long;
  logic [31:0]   arg;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    short_cmd = 1'b0;
    exec_long = 1'b0;
    // A strobe in the timeout cycle wins, so timeout is qualified by !rx_stb_i.
    timeout   = (state == ARG) && !bus.rx_stb_i && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    arg       = {bus.rx_data_i, arg_lo};
    case (state)
      IDLE: begin
        if (bus.rx_stb_i) begin
          if (bus.rx_data_i[7]) state_nxt = ARG;
          else                  short_cmd = 1'b1;
        end
      end
      ARG: begin
        if (bus.rx_stb_i && idx == 2'd3) begin
          state_nxt = IDLE;
          exec_long = 1'b1;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      idx                 <= '0;
      opcode              <= '0;
      arg_lo              <= '0;
      tmo_cnt             <= '0;
      bus.cfg_div_o       <= '0;
      bus.cfg_read_cnt_o  <= '0;
      bus.cfg_delay_cnt_o <= '0;
      bus.cfg_flags_o     <= '0;
      bus.trg_msk_o       <= '0;
      bus.trg_val_o       <= '0;
      bus.trg_cfg_o       <= '0;
      bus.cfg_upd_o       <= 1'b0;
      bus.tx_en_o         <= 1'b1;
      bus.soft_reset_o    <= 1'b0;
      bus.run_o           <= 1'b0;
      bus.id_req_o        <= 1'b0;
      bus.meta_req_o      <= 1'b0;
      bus.finish_o        <= 1'b0;
      bus.query_in_o      <= 1'b0;
      bus.arm_o           <= 1'b0;
    end else begin
      bus.cfg_upd_o    <= 1'b0;
      bus.soft_reset_o <= 1'b0;
      bus.run_o        <= 1'b0;
      bus.id_req_o     <= 1'b0;
      bus.meta_req_o   <= 1'b0;
      bus.finish_o     <= 1'b0;
      bus.query_in_o   <= 1'b0;
      bus.arm_o        <= 1'b0;

      if (bus.rx_stb_i || state != ARG) tmo_cnt <= '0;
      else                              tmo_cnt <= tmo_cnt + CW'(1);

      if (state == IDLE && bus.rx_stb_i && bus.rx_data_i[7]) begin
        opcode <= bus.rx_data_i;
        idx    <= '0;
      end

      if (state == ARG && bus.rx_stb_i) begin
        idx <= idx + 2'd1;
        case (idx)
          2'd0:    arg_lo[7:0]   <= bus.rx_data_i;
          2'd1:    arg_lo[15:8]  <= bus.rx_data_i;
          2'd2:    arg_lo[23:16] <= bus.rx_data_i;
          default: ;
        endcase
      end

      if (short_cmd) begin
        case (bus.rx_data_i)
          8'h00: begin
            bus.soft_reset_o    <= 1'b1;
            bus.cfg_div_o       <= '0;
            bus.cfg_read_cnt_o  <= '0;
            bus.cfg_delay_cnt_o <= '0;
            bus.cfg_flags_o     <= '0;
            bus.trg_msk_o       <= '0;
            bus.trg_val_o       <= '0;
            bus.trg_cfg_o       <= '0;
            bus.tx_en_o         <= 1'b1;
          end
          8'h01:   bus.run_o      <= 1'b1;
          8'h02:   bus.id_req_o   <= 1'b1;
          8'h04:   bus.meta_req_o <= 1'b1;
          8'h05:   bus.finish_o   <= 1'b1;
          8'h06:   bus.query_in_o <= 1'b1;
          8'h0F:   bus.arm_o      <= 1'b1;
          8'h11:   bus.tx_en_o    <= 1'b1;
          8'h13:   bus.tx_en_o    <= 1'b0;
          default: ;
        endcase
      end

      // Non-stage-0 trigger words and unknown long opcodes fall through to default.
      if (exec_long) begin
        case (opcode)
          8'h80: begin
            bus.cfg_div_o <= arg[23:0];
            bus.cfg_upd_o <= 1'b1;
          end
          8'h81: begin
            bus.cfg_read_cnt_o  <= arg[15:0];
            bus.cfg_delay_cnt_o <= arg[31:16];
            bus.cfg_upd_o       <= 1'b1;
          end
          8'h82: begin
            bus.cfg_flags_o <= arg[15:0];
            bus.cfg_upd_o   <= 1'b1;
          end
          8'hC0: begin
            bus.trg_msk_o <= arg;
            bus.cfg_upd_o <= 1'b1;
          end
          8'hC1: begin
            bus.trg_val_o <= arg;
            bus.cfg_upd_o <= 1'b1;
          end
          8'hC2: begin
            bus.trg_cfg_o <= arg;
            bus.cfg_upd_o <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
